alu_share_arbiter: RTL and testbench

Shares the single integer ALU (4-bit ALUControl encoding: 0000 AND, 0001 OR, 0010 ADD, 0011 branch compare, 0100 XOR, 0101 SRL, 0110 SUB, 0111 SLT, 1000 SLTU, 1001 SRA) between NUM_REQ requesters, for example the execute stage and the address/branch unit.
- Round-robin arbitration with a valid/ready request handshake.
- Drives the ALU from registered operands, captures the result, and returns it with the requester ID on a valid/ready response channel.
- Sits between the issue logic and the ALU; the ALU itself stays purely combinational.

---
 rtl/alu_share_arbiter.sv | 95 +++++++++
 tb/tb_alu_share_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU among NUM_REQ requesters (ports: req_* in, alu_* out/in, rsp_* out, busy); `define ALU_ARB_STATS_EN adds grant_cnt
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN = 32,
  parameter int ID_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [4*NUM_REQ-1:0] req_ctrl,
  input  logic [XLEN*NUM_REQ-1:0] req_a,
  input  logic [XLEN*NUM_REQ-1:0] req_b,
  output logic [3:0] alu_ctrl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic alu_zero,
  output logic rsp_valid,
  input  logic rsp_ready,
  output logic [ID_W-1:0] rsp_id,
  output logic [XLEN-1:0] rsp_result,
  output logic rsp_zero,
`ifdef ALU_ARB_STATS_EN
  output logic [16*NUM_REQ-1:0] grant_cnt,
`endif
  output logic busy
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
  logic [1:0] state_q, state_d;
  logic [ID_W-1:0] last_q, last_d, id_q, id_d, win;
  logic [3:0] ctrl_q, ctrl_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic zero_q, zero_d, arb_en, found, accept;
  always_comb begin
    arb_en = !rst && (state_q == IDLE || (state_q == RESP && rsp_ready));
    found = 1'b0;
    win = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && 1'(req_valid >> ((int'(last_q) + k) % NUM_REQ))) begin
        found = 1'b1;
        win = ID_W'((int'(last_q) + k) % NUM_REQ);
      end
    end
    accept = arb_en && found;
    req_ready = accept ? (NUM_REQ'(1) << win) : '0;
    state_d = accept ? EXEC : state_q == EXEC ? RESP : (state_q == RESP && rsp_ready) ? IDLE : state_q;
    last_d = accept ? win : last_q;
    id_d = accept ? win : id_q;
    ctrl_d = accept ? 4'(req_ctrl >> (4 * int'(win))) : ctrl_q;
    a_d = accept ? XLEN'(req_a >> (XLEN * int'(win))) : a_q;
    b_d = accept ? XLEN'(req_b >> (XLEN * int'(win))) : b_q;
    res_d = state_q == EXEC ? alu_result : res_q;
    zero_d = state_q == EXEC ? alu_zero : zero_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= ID_W'(NUM_REQ - 1);
      id_q <= '0;
      ctrl_q <= 4'b0010;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      id_q <= id_d;
      ctrl_q <= ctrl_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      zero_q <= zero_d;
    end
  end
  assign alu_ctrl = ctrl_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign rsp_valid = state_q == RESP;
  assign rsp_id = id_q;
  assign rsp_result = res_q;
  assign rsp_zero = zero_q;
  assign busy = state_q != IDLE;
`ifdef ALU_ARB_STATS_EN
  logic [16*NUM_REQ-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_REQ; i++)
      if (accept && int'(win) == i && cnt_q[16*i +: 16] != 16'hFFFF) cnt_d[16*i +: 16] = cnt_q[16*i +: 16] + 16'd1;
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req_valid = '0, req_ready;
  logic [7:0] req_ctrl = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic [3:0] alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_result, rsp_result;
  logic alu_zero, rsp_valid, rsp_ready = 1'b0, rsp_zero, busy;
  logic [1:0] rsp_id;
  int total = 0, bad = 0;
`ifdef ALU_ARB_STATS_EN
  logic [31:0] grant_cnt;
`endif
  alu_share_arbiter #(.NUM_REQ(2), .XLEN(32), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_ctrl(req_ctrl), .req_a(req_a), .req_b(req_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt(grant_cnt),
`endif
    .busy(busy));
  always #5 clk = ~clk;
  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a - b;
      4'd4: return a ^ b;
      4'd5: return a >> b[4:0];
      4'd6: return a - b;
      4'd7: return {31'b0, $signed(a) < $signed(b)};
      4'd8: return {31'b0, a < b};
      4'd9: return $signed(a) >>> b[4:0];
      default: return 32'd0;
    endcase
  endfunction
  always_comb begin
    alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
    alu_zero = alu_result == 32'd0;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req_ctrl[4*i +: 4] = c;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic run_op(input int i, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    set_req(i, c, a, b);
    req_valid = 2'b01 << i;
    #1;
    tick();
    req_valid = '0;
    tick();
  endtask
  task automatic test_reset();
    do_reset();
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    total++; if (alu_ctrl !== 4'b0010) begin bad++; $display("FAIL reset_alu_ctrl got=%b exp=0010", alu_ctrl); end
    total++; if (alu_a !== 0 || alu_b !== 0) begin bad++; $display("FAIL reset_alu_ab got=%h/%h exp=0/0", alu_a, alu_b); end
    total++; if ({rsp_valid, rsp_id, rsp_result, rsp_zero, busy} !== '0) begin bad++; $display("FAIL reset_rsp got v=%b id=%0d r=%h z=%b busy=%b exp all 0", rsp_valid, rsp_id, rsp_result, rsp_zero, busy); end
  endtask
  task automatic test_single_op();
    do_reset();
    set_req(0, 4'b0110, 32'd10, 32'd3);
    req_valid = 2'b01;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b exp=01", req_ready); end
    tick();
    req_valid = '0;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b1 || alu_ctrl !== 4'b0110 || alu_a !== 32'd10 || alu_b !== 32'd3) begin bad++; $display("FAIL single_exec got v=%b busy=%b ctrl=%b a=%0d b=%0d exp 0 1 0110 10 3", rsp_valid, busy, alu_ctrl, alu_a, alu_b); end
    tick();
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'd7 || rsp_zero !== 1'b0) begin bad++; $display("FAIL single_rsp got v=%b id=%0d r=%0d z=%b exp 1 0 7 0", rsp_valid, rsp_id, rsp_result, rsp_zero); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_done got v=%b busy=%b exp 0 0", rsp_valid, busy); end
  endtask
  task automatic test_contention();
    do_reset();
    set_req(0, 4'd2, 32'd1, 32'd2);
    set_req(1, 4'd6, 32'd9, 32'd4);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      total++; if (req_ready !== (2'b01 << (g % 2))) begin bad++; $display("FAIL contend_grant%0d got=%b exp=%b", g, req_ready, 2'b01 << (g % 2)); end
      if (g > 0) begin
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((g - 1) % 2) || rsp_result !== ((g % 2) == 1 ? 32'd3 : 32'd5)) begin bad++; $display("FAIL contend_rsp%0d got v=%b id=%0d r=%0d", g, rsp_valid, rsp_id, rsp_result); end
      end
      tick();
      total++; if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL contend_exec%0d got rdy=%b v=%b busy=%b exp 00 0 1", g, req_ready, rsp_valid, busy); end
      tick();
    end
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 32'd5) begin bad++; $display("FAIL contend_last got v=%b id=%0d r=%0d exp 1 1 5", rsp_valid, rsp_id, rsp_result); end
    req_valid = '0;
    tick();
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL contend_idle got v=%b busy=%b exp 0 0", rsp_valid, busy); end
  endtask
  task automatic test_backpressure();
    do_reset();
    set_req(1, 4'd2, 32'd5, 32'd6);
    req_valid = 2'b10;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_ready got=%b exp=10", req_ready); end
    tick();
    req_valid = '0;
    tick();
    set_req(0, 4'd4, 32'hF0, 32'h0F);
    req_valid = 2'b01;
    #1;
    for (int c = 0; c < 5; c++) begin
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 32'd11 || req_ready !== 2'b00) begin bad++; $display("FAIL bp_hold%0d got v=%b id=%0d r=%0d rdy=%b exp 1 1 11 00", c, rsp_valid, rsp_id, rsp_result, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL bp_release got=%b exp=01", req_ready); end
    tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0 || alu_ctrl !== 4'd4 || alu_a !== 32'hF0) begin bad++; $display("FAIL bp_exec got v=%b ctrl=%0d a=%h exp 0 4 f0", rsp_valid, alu_ctrl, alu_a); end
    tick();
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'hFF) begin bad++; $display("FAIL bp_rsp2 got v=%b id=%0d r=%h exp 1 0 ff", rsp_valid, rsp_id, rsp_result); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask
  task automatic test_zero_slt();
    do_reset();
    run_op(0, 4'b0011, 32'h55, 32'h55);
    total++; if (rsp_valid !== 1'b1 || rsp_zero !== 1'b1 || rsp_result !== 32'd0) begin bad++; $display("FAIL zero_flag got v=%b z=%b r=%h exp 1 1 0", rsp_valid, rsp_zero, rsp_result); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    run_op(1, 4'b0111, 32'hFFFF_FFFF, 32'd1);
    total++; if (rsp_id !== 2'd1 || rsp_result !== 32'd1 || rsp_zero !== 1'b0) begin bad++; $display("FAIL slt got id=%0d r=%h z=%b exp 1 1 0", rsp_id, rsp_result, rsp_zero); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    run_op(0, 4'b1001, 32'h8000_0000, 32'd4);
    total++; if (rsp_result !== 32'hF800_0000) begin bad++; $display("FAIL sra got r=%h exp f8000000", rsp_result); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask
  task automatic test_reset_mid_op();
    do_reset();
    set_req(0, 4'd0, 32'hFF, 32'h0F);
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_ctrl !== 4'b0010 || alu_a !== 32'd0) begin bad++; $display("FAIL midrst_state got v=%b busy=%b ctrl=%b a=%h exp 0 0 0010 0", rsp_valid, busy, alu_ctrl, alu_a); end
    for (int c = 0; c < 4; c++) begin
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_norsp%0d got v=%b exp 0", c, rsp_valid); end
      tick();
    end
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL midrst_prio got=%b exp=01", req_ready); end
    req_valid = '0;
    tick();
  endtask
  task automatic test_random();
    logic [34:0] q[$];
    logic [1:0] exp_ready;
    int last = 1, w;
    bit exec = 0, exp_valid;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          logic [31:0] a = $urandom;
          set_req(i, 4'($urandom_range(0, 15)), a, $urandom_range(0, 3) == 0 ? a : $urandom);
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      w = -1;
      if (!exec && (q.size() == 0 || rsp_ready))
        for (int k = 1; k <= 2; k++)
          if (w < 0 && req_valid[(last + k) % 2]) w = (last + k) % 2;
      exp_ready = w >= 0 ? 2'b01 << w : 2'b00;
      exp_valid = q.size() != 0 && !exec;
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, req_ready, exp_ready); end
      total++; if (rsp_valid !== exp_valid || busy !== (exec || q.size() != 0)) begin bad++; $display("FAIL rand_valid n=%0d got v=%b busy=%b exp v=%b", n, rsp_valid, busy, exp_valid); end
      if (exp_valid) begin
        total++; if ({rsp_id, rsp_zero, rsp_result} !== q[0]) begin bad++; $display("FAIL rand_rsp n=%0d got id=%0d z=%b r=%h exp %h", n, rsp_id, rsp_zero, rsp_result, q[0]); end
        if (rsp_ready) void'(q.pop_front());
      end
      exec = w >= 0;
      if (w >= 0) begin
        logic [31:0] r = alu_fn(req_ctrl[4*w +: 4], req_a[32*w +: 32], req_b[32*w +: 32]);
        q.push_back({2'(w), r == 32'd0, r});
        last = w;
      end
      tick();
      req_valid = req_valid & ~exp_ready;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    tick();
    rsp_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand_drain got busy=%b exp 0", busy); end
  endtask
`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    rsp_ready = 1'b1;
    run_op(1, 4'd2, 32'd1, 32'd1);
    run_op(0, 4'd2, 32'd1, 32'd1);
    run_op(1, 4'd2, 32'd1, 32'd1);
    run_op(1, 4'd2, 32'd1, 32'd1);
    tick();
    total++; if (grant_cnt !== {16'd3, 16'd1}) begin bad++; $display("FAIL stats_cnt got=%h exp=00030001", grant_cnt); end
    force dut.cnt_q[31:16] = 16'hFFFE;
    #1;
    release dut.cnt_q[31:16];
    run_op(1, 4'd2, 32'd1, 32'd1);
    run_op(1, 4'd2, 32'd1, 32'd1);
    tick();
    total++; if (grant_cnt[31:16] !== 16'hFFFF) begin bad++; $display("FAIL stats_sat got=%h exp=ffff", grant_cnt[31:16]); end
    rsp_ready = 1'b0;
  endtask
`endif
  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_zero_slt();
    test_reset_mid_op();
    test_random();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
